// File: rtl/detector_paridade_quadro_pkg.sv
// Shared types and constants for the frame parity detector.
// Defines the FSM state type, parity-mode constants and the parity helper.
package pacote_paridade;

    // FSM states: collecting data bits, then waiting for the parity bit.
    typedef enum logic [0:0] {
        DADOS    = 1'b0,
        PARIDADE = 1'b1
    } estado_paridade_t;

    localparam logic PARIDADE_PAR   = 1'b0;
    localparam logic PARIDADE_IMPAR = 1'b1;

    // Parity bit to transmit for a given data XOR and parity mode.
    function automatic logic paridade_tx(input logic acc, input logic modo);
        return acc ^ modo;
    endfunction

endpackage

// File: rtl/detector_paridade_quadro_contador.sv
// Saturating up-counter used for the parity error count.
// It stops at all-ones and never wraps around.
module contador_saturado #(
    parameter int LARGURA = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               incr,
    output logic [LARGURA-1:0] valor
);

    localparam logic [LARGURA-1:0] VALOR_MAX = {LARGURA{1'b1}};

    logic [LARGURA-1:0] valor_d;
    logic [LARGURA-1:0] valor_q;

    // Next count: step by one on request unless already saturated.
    always_comb begin
        valor_d = valor_q;
        if (incr && (valor_q != VALOR_MAX)) begin
            valor_d = valor_q + {{(LARGURA-1){1'b0}}, 1'b1};
        end else begin
            valor_d = valor_q;
        end
    end

    // Count register, cleared only by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valor_q <= {LARGURA{1'b0}};
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/detector_paridade_quadro.sv
// Serial frame parity detector: LARGURA data bits followed by one parity
// bit, with back-to-back frames, gap tolerance and synchronous abort.
// The error counter is built only when DETECTOR_PARIDADE_CONTADOR_EN is
// defined; otherwise cont_erros is tied to zero.
module detector_paridade_quadro
    import pacote_paridade::*;
#(
    parameter int LARGURA      = 8,
    parameter int MODO_IMPAR   = 0,
    parameter int LARGURA_CONT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_bit,
    input  logic                    in_limpa,
    output logic                    out_bit,
    output logic                    out_paridade,
    output logic                    quadro_ok,
    output logic                    erro_paridade,
    output logic [LARGURA_CONT-1:0] cont_erros
);

    localparam int               CW       = $clog2(LARGURA + 1);
    localparam logic [CW-1:0]    CONT_ULT = CW'(LARGURA - 1);
    localparam logic [CW-1:0]    CONT_FIM = CW'(LARGURA);
    localparam logic             MODO_BIT = (MODO_IMPAR != 0) ? PARIDADE_IMPAR : PARIDADE_PAR;

    estado_paridade_t estado_d, estado_q;
    logic             par_d, par_q;
    logic [CW-1:0]    cont_d, cont_q;
    logic             ok_d, ok_q;
    logic             erro_d, erro_q;

    // Decode of the parity register only; in_bit has no path to these.
    assign out_bit      = par_q;
    assign out_paridade = paridade_tx(par_q, MODO_BIT);

    // Next-state logic: abort wins, idle cycles hold, otherwise advance the frame.
    always_comb begin
        estado_d = estado_q;
        par_d    = par_q;
        cont_d   = cont_q;
        ok_d     = 1'b0;
        erro_d   = 1'b0;
        if (in_limpa) begin
            estado_d = DADOS;
            par_d    = 1'b0;
            cont_d   = {CW{1'b0}};
        end else if (in_valid) begin
            case (estado_q)
                DADOS: begin
                    par_d = par_q ^ in_bit;
                    if (cont_q == CONT_ULT) begin
                        cont_d   = CONT_FIM;
                        estado_d = PARIDADE;
                    end else begin
                        cont_d   = cont_q + {{(CW-1){1'b0}}, 1'b1};
                        estado_d = DADOS;
                    end
                end
                PARIDADE: begin
                    if (in_bit == out_paridade) begin
                        ok_d = 1'b1;
                    end else begin
                        erro_d = 1'b1;
                    end
                    par_d    = 1'b0;
                    cont_d   = {CW{1'b0}};
                    estado_d = DADOS;
                end
                default: begin
                    par_d    = 1'b0;
                    cont_d   = {CW{1'b0}};
                    estado_d = DADOS;
                end
            endcase
        end else begin
            estado_d = estado_q;
        end
    end

    // Frame state and registered result pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= DADOS;
            par_q    <= 1'b0;
            cont_q   <= {CW{1'b0}};
            ok_q     <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            par_q    <= par_d;
            cont_q   <= cont_d;
            ok_q     <= ok_d;
            erro_q   <= erro_d;
        end
    end

    assign quadro_ok     = ok_q;
    assign erro_paridade = erro_q;

`ifdef DETECTOR_PARIDADE_CONTADOR_EN
    // Counter steps on the same edge that raises erro_paridade.
    contador_saturado #(
        .LARGURA (LARGURA_CONT)
    ) u_contador (
        .clk   (clk),
        .reset (reset),
        .incr  (erro_d),
        .valor (cont_erros)
    );
`else
    assign cont_erros = {LARGURA_CONT{1'b0}};
`endif

endmodule
